// File: rtl/tc_sram_tiled.sv
// Tiled single-port SRAM wrapper: builds a NumWords x DataWidth memory from a
// grid of word-write-only tiles and handles partial-byte writes with an
// internal read-modify-write (IDLE -> MERGE -> IDLE).
//
// Handshake: a request transfers when req_i & gnt_o; gnt_o is low only during
// MERGE. Reads answer exactly one cycle after acceptance with a one-cycle
// rvalid_o pulse; rdata_o holds the last response until the next one.
module tc_sram_tiled #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 128,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned TileWords = 256,
    parameter int unsigned TileWidth = 64,
    parameter string       SimInit   = "none",
    parameter int unsigned AddrWidth = (NumWords > 32'd1) ? $clog2(NumWords) : 32'd1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [BeWidth-1:0]   be_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rerr_o
);

    localparam int unsigned Rows     = (NumWords + TileWords - 1) / TileWords;
    localparam int unsigned Cols     = (DataWidth + TileWidth - 1) / TileWidth;
    localparam int unsigned PadWidth = Cols * TileWidth;
    localparam int unsigned LocalW   = (TileWords > 32'd1) ? $clog2(TileWords) : 32'd1;
    localparam int unsigned RowW     = (Rows > 32'd1) ? $clog2(Rows) : 32'd1;

    typedef enum logic {IDLE, MERGE} state_e;

    state_e                state_q, state_d;
    logic [31:0]           addr_ext;
    logic [RowW-1:0]       row_i;
    logic [LocalW-1:0]     local_i;
    logic                  in_range_i;
    logic                  accept, rd_acc, full_wr, part_wr;

    logic [RowW-1:0]       lat_row_q;
    logic [LocalW-1:0]     lat_local_q;
    logic [DataWidth-1:0]  lat_wdata_q;
    logic [BeWidth-1:0]    lat_be_q;

    logic                  rvalid_q, rerr_q;
    logic [RowW-1:0]       rd_row_q;
    logic [DataWidth-1:0]  rdata_q;

    logic                  t_cen, t_we;
    logic [RowW-1:0]       t_row;
    logic [LocalW-1:0]     t_addr;
    logic [PadWidth-1:0]   t_wdata;
    logic [PadWidth-1:0]   merged, merge_src, rd_row_data;
    logic [Rows-1:0]       row_cen;
    logic [TileWidth-1:0]  tile_q [Rows][Cols];
    logic [PadWidth-1:0]   row_q  [Rows];

    // Address decode: row = addr / TileWords, local = addr % TileWords.
    assign addr_ext   = 32'(addr_i);
    assign row_i      = RowW'(addr_ext / TileWords);
    assign local_i    = LocalW'(addr_ext % TileWords);
    assign in_range_i = (addr_ext < NumWords);

    assign gnt_o   = (state_q == IDLE);
    assign accept  = req_i & gnt_o;
    assign rd_acc  = accept & ~we_i;
    // Out-of-range writes are dropped outright, partial ones never enter MERGE.
    assign full_wr = accept & we_i & (&be_i) & in_range_i;
    assign part_wr = accept & we_i & (|be_i) & ~(&be_i) & in_range_i;

    // Byte merge of latched write data over the tile read issued at accept.
    always_comb begin
        merged    = '0;
        merge_src = row_q[lat_row_q];
        for (int unsigned b = 0; b < DataWidth; b++) begin
            merged[b] = lat_be_q[b / ByteWidth] ? lat_wdata_q[b] : merge_src[b];
        end
    end

    // Next state and the shared tile command bus.
    always_comb begin
        state_d = state_q;
        t_cen   = 1'b0;
        t_we    = 1'b0;
        t_row   = row_i;
        t_addr  = local_i;
        t_wdata = PadWidth'(wdata_i);
        unique case (state_q)
            IDLE: begin
                if (rd_acc && in_range_i) t_cen = 1'b1;
                if (full_wr) begin
                    t_cen = 1'b1;
                    t_we  = 1'b1;
                end
                if (part_wr) begin
                    t_cen   = 1'b1;
                    state_d = MERGE;
                end
            end
            MERGE: begin
                t_cen   = 1'b1;
                t_we    = 1'b1;
                t_row   = lat_row_q;
                t_addr  = lat_local_q;
                t_wdata = merged;
                state_d = IDLE;
            end
        endcase
    end

    // State, RMW latches and read-response tracking.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lat_row_q   <= '0;
            lat_local_q <= '0;
            lat_wdata_q <= '0;
            lat_be_q    <= '0;
            rvalid_q    <= 1'b0;
            rerr_q      <= 1'b0;
            rd_row_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q  <= state_d;
            rvalid_q <= rd_acc;
            rerr_q   <= rd_acc & ~in_range_i;
            if (rd_acc) rd_row_q <= row_i;
            if (rvalid_q) rdata_q <= rdata_o;
            if (part_wr) begin
                lat_row_q   <= row_i;
                lat_local_q <= local_i;
                lat_wdata_q <= wdata_i;
                lat_be_q    <= be_i;
            end
        end
    end

    // Tile grid: only the selected row sees an active enable.
    for (genvar r = 0; r < Rows; r++) begin : g_row
        assign row_cen[r] = t_cen & (t_row == RowW'(r));
        for (genvar c = 0; c < Cols; c++) begin : g_col
            logic [TileWidth-1:0] mem [TileWords];
            logic [TileWidth-1:0] q;
            // Behavioural tile: whole-word write, one-cycle read, q holds.
            always_ff @(posedge clk_i) begin
                if (row_cen[r]) begin
                    if (t_we) mem[t_addr] <= t_wdata[c*TileWidth +: TileWidth];
                    else      q           <= mem[t_addr];
                end
            end
            assign tile_q[r][c] = q;
`ifndef SYNTHESIS
            initial begin
                for (int unsigned i = 0; i < TileWords; i++) begin
                    if (SimInit == "zeros")     mem[i] = '0;
                    else if (SimInit == "ones") mem[i] = '1;
                    else                        mem[i] = 'x;
                end
            end
`endif
        end
    end

    // Pack tile outputs into padded row words.
    always_comb begin
        for (int unsigned r = 0; r < Rows; r++) begin
            row_q[r] = '0;
            for (int unsigned c = 0; c < Cols; c++) begin
                row_q[r][c*TileWidth +: TileWidth] = tile_q[r][c];
            end
        end
    end

    // Read response: live tile data in the rvalid cycle, held copy otherwise.
    always_comb begin
        rd_row_data = row_q[rd_row_q];
        if (rvalid_q) rdata_o = rerr_q ? '0 : rd_row_data[DataWidth-1:0];
        else          rdata_o = rdata_q;
    end

    assign rvalid_o = rvalid_q;
    assign rerr_o   = rerr_q;

    if (PadWidth > DataWidth) begin : g_pad
        logic unused_pad_bits;
        assign unused_pad_bits = ^{rd_row_data[PadWidth-1:DataWidth],
                                   merge_src[PadWidth-1:DataWidth]};
    end

`ifndef SYNTHESIS
    initial begin
        if (NumWords == 0 || DataWidth == 0 || ByteWidth == 0 ||
            TileWords == 0 || TileWidth == 0)
            $error("tc_sram_tiled: all sizes must be > 0");
        if ((TileWords & (TileWords - 1)) != 0)
            $error("tc_sram_tiled: TileWords must be a power of two");
    end
`endif

endmodule

// File: tb/tb_tc_sram_tiled.sv
// Directed self-checking bench for tc_sram_tiled (1000 x 120, 256 x 64 tiles).
module tb_tc_sram_tiled;

    localparam int unsigned NW  = 1000;
    localparam int unsigned DW  = 120;
    localparam int unsigned AW  = 10;
    localparam int unsigned BEW = 15;

    logic            clk_i   = 1'b0;
    logic            rst_ni  = 1'b0;
    logic            req_i   = 1'b0;
    logic            we_i    = 1'b0;
    logic [AW-1:0]   addr_i  = '0;
    logic [DW-1:0]   wdata_i = '0;
    logic [BEW-1:0]  be_i    = '0;
    logic            gnt_o, rvalid_o, rerr_o;
    logic [DW-1:0]   rdata_o;

    int n_cmp = 0;
    int n_bad = 0;

    tc_sram_tiled #(
        .NumWords (NW),
        .DataWidth(DW),
        .ByteWidth(8),
        .TileWords(256),
        .TileWidth(64),
        .SimInit  ("zeros")
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .gnt_o   (gnt_o),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rvalid_o(rvalid_o),
        .rdata_o (rdata_o),
        .rerr_o  (rerr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input int unsigned addr,
                         input logic [DW-1:0] wdata, input logic [BEW-1:0] be);
        req_i   = req;
        we_i    = we;
        addr_i  = AW'(addr);
        wdata_i = wdata;
        be_i    = be;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, '0, '0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        step();
        step();
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL reset_gnt: got %b want 1", gnt_o); end
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid_o); end
        n_cmp++; if (rerr_o !== 1'b0) begin n_bad++; $display("FAIL reset_rerr: got %b want 0", rerr_o); end
        n_cmp++; if (rdata_o !== '0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_full_write_read();
        logic [DW-1:0] d;
        logic [63:0]   t;
        d = {88'h0123456789ABCDEF012345, 32'hDEADBEEF};
        drive(1'b1, 1'b1, 999, d, 15'h7FFF);
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL fw_gnt: got %b want 1", gnt_o); end
        step();
        drive(1'b1, 1'b0, 999, '0, '0);
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL fw_rd_gnt: got %b want 1", gnt_o); end
        step();
        idle();
        n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL fw_rvalid: got %b want 1", rvalid_o); end
        n_cmp++; if (rdata_o !== d) begin n_bad++; $display("FAIL fw_rdata: got %h want %h", rdata_o, d); end
        n_cmp++; if (rerr_o !== 1'b0) begin n_bad++; $display("FAIL fw_rerr: got %b want 0", rerr_o); end
        step();
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL fw_rvalid_pulse: got %b want 0", rvalid_o); end
        n_cmp++; if (rdata_o !== d) begin n_bad++; $display("FAIL fw_rdata_hold: got %h want %h", rdata_o, d); end
        // Address 999 = row 3, local 231; upper 8 bits of column 1 are padding.
        t = dut.g_row[3].g_col[1].mem[231];
        n_cmp++; if (t[63:56] !== 8'h00) begin n_bad++; $display("FAIL fw_pad_bits: got %h want 00", t[63:56]); end
        n_cmp++; if (t[55:0] !== d[119:64]) begin n_bad++; $display("FAIL fw_col1_data: got %h want %h", t[55:0], d[119:64]); end
    endtask

    task automatic test_partial_merge();
        logic [DW-1:0] exp_d;
        exp_d = {{11{8'h11}}, {4{8'hAA}}};
        drive(1'b1, 1'b1, 5, {15{8'h11}}, 15'h7FFF);
        step();
        drive(1'b1, 1'b1, 5, {15{8'hAA}}, 15'h000F);
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL pm_gnt_accept: got %b want 1", gnt_o); end
        step();
        idle();
        n_cmp++; if (gnt_o !== 1'b0) begin n_bad++; $display("FAIL pm_gnt_merge: got %b want 0", gnt_o); end
        step();
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL pm_gnt_after: got %b want 1", gnt_o); end
        drive(1'b1, 1'b0, 5, '0, '0);
        step();
        idle();
        n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL pm_rvalid: got %b want 1", rvalid_o); end
        n_cmp++; if (rdata_o !== exp_d) begin n_bad++; $display("FAIL pm_rdata: got %h want %h", rdata_o, exp_d); end
        step();
    endtask

    task automatic test_stall();
        logic [DW-1:0] exp_d;
        exp_d = {{3{8'h55}}, 96'h0};
        drive(1'b1, 1'b1, 300, {15{8'h55}}, 15'h7000);
        step();
        // Read held during MERGE; its we/addr/data must not disturb the merge.
        drive(1'b1, 1'b0, 300, {15{8'hEE}}, 15'h7FFF);
        n_cmp++; if (gnt_o !== 1'b0) begin n_bad++; $display("FAIL st_gnt_merge: got %b want 0", gnt_o); end
        step();
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL st_gnt_release: got %b want 1", gnt_o); end
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL st_no_early_rvalid: got %b want 0", rvalid_o); end
        step();
        idle();
        n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL st_rvalid: got %b want 1", rvalid_o); end
        n_cmp++; if (rdata_o !== exp_d) begin n_bad++; $display("FAIL st_rdata: got %h want %h", rdata_o, exp_d); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] d;
        for (int i = 0; i < 3; i++) begin
            d = {15{8'(8'h20 + i)}};
            exp_q.push_back(d);
            drive(1'b1, 1'b1, 10 + i, d, 15'h7FFF);
            n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL b2b_wr_gnt%0d: got %b want 1", i, gnt_o); end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 10 + i, '0, '0);
            step();
            d = exp_q.pop_front();
            n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid%0d: got %b want 1", i, rvalid_o); end
            n_cmp++; if (rdata_o !== d) begin n_bad++; $display("FAIL b2b_rdata%0d: got %h want %h", i, rdata_o, d); end
        end
        idle();
        step();
    endtask

    task automatic test_out_of_range();
        logic [63:0] t0, t1;
        logic [DW-1:0] exp_d;
        drive(1'b1, 1'b0, 1010, '0, '0);
        step();
        idle();
        n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL oor_rvalid: got %b want 1", rvalid_o); end
        n_cmp++; if (rerr_o !== 1'b1) begin n_bad++; $display("FAIL oor_rerr: got %b want 1", rerr_o); end
        n_cmp++; if (rdata_o !== '0) begin n_bad++; $display("FAIL oor_rdata: got %h want 0", rdata_o); end
        drive(1'b1, 1'b1, 1010, {15{8'hFF}}, 15'h7FFF);
        step();
        idle();
        n_cmp++; if (rerr_o !== 1'b0) begin n_bad++; $display("FAIL oor_rerr_pulse: got %b want 0", rerr_o); end
        // Address 1010 = row 3, local 242 (a padding word of the last row).
        t0 = dut.g_row[3].g_col[0].mem[242];
        t1 = dut.g_row[3].g_col[1].mem[242];
        n_cmp++; if (t0 !== 64'h0) begin n_bad++; $display("FAIL oor_wr_col0: got %h want 0", t0); end
        n_cmp++; if (t1 !== 64'h0) begin n_bad++; $display("FAIL oor_wr_col1: got %h want 0", t1); end
        // be = 0 write: accepted, memory untouched.
        drive(1'b1, 1'b1, 5, {15{8'hFF}}, 15'h0000);
        step();
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL be0_gnt: got %b want 1", gnt_o); end
        drive(1'b1, 1'b0, 5, '0, '0);
        step();
        idle();
        exp_d = {{11{8'h11}}, {4{8'hAA}}};
        n_cmp++; if (rdata_o !== exp_d) begin n_bad++; $display("FAIL be0_rdata: got %h want %h", rdata_o, exp_d); end
        step();
    endtask

    task automatic test_reset_mid_merge();
        logic [DW-1:0] p;
        p = {15{8'h3C}};
        drive(1'b1, 1'b1, 7, p, 15'h7FFF);
        step();
        drive(1'b1, 1'b1, 7, {15{8'hFF}}, 15'h0001);
        step();
        idle();
        n_cmp++; if (gnt_o !== 1'b0) begin n_bad++; $display("FAIL rm_in_merge: got %b want 0", gnt_o); end
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (gnt_o !== 1'b1) begin n_bad++; $display("FAIL rm_gnt: got %b want 1", gnt_o); end
        n_cmp++; if (rvalid_o !== 1'b0) begin n_bad++; $display("FAIL rm_rvalid: got %b want 0", rvalid_o); end
        n_cmp++; if (rdata_o !== '0) begin n_bad++; $display("FAIL rm_rdata: got %h want 0", rdata_o); end
        step();
        step();
        rst_ni = 1'b1;
        step();
        drive(1'b1, 1'b0, 7, '0, '0);
        step();
        idle();
        n_cmp++; if (rvalid_o !== 1'b1) begin n_bad++; $display("FAIL rm_rd_rvalid: got %b want 1", rvalid_o); end
        n_cmp++; if (rdata_o !== p) begin n_bad++; $display("FAIL rm_unchanged: got %h want %h", rdata_o, p); end
        step();
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_merge();
        test_stall();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_merge();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
